chi5pc_pcrd_tracker: RTL

Parametrised protocol-credit tracker for the Chi5PC protocol-checker family: it follows every RetryAck → PCrdGrant → reissued-request sequence on one CHI link. It generalises the single-credit grant record to N concurrent outstanding retries, configurable node-ID, TxnID and PCrdType widths, and an optional grant-wait watchdog. It sits beside the REQ/RSP channel checkers and raises registered single-cycle error pulses for protocol violations.

---
 rtl/chi5pc_pcrd_tracker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/chi5pc_pcrd_tracker.sv
// Chi5PC protocol-credit tracker: follows RetryAck -> PCrdGrant -> reissued request
// for up to NUM_ENTRIES concurrent retries and raises registered error pulses.
//
// state      | meaning
// FREE       | slot available for a new RetryAck
// WAIT_GRANT | request retried, waiting for a matching PCrdGrant
// GRANTED    | credit held, waiting for the AllowRetry=0 reissue
module chi5pc_pcrd_tracker #(
    parameter int NUM_ENTRIES = 8,
    parameter int SRCID_W     = 7,
    parameter int TXNID_W     = 8,
    parameter int PCRDTYPE_W  = 4,
    parameter int MAXWAIT     = 0
) (
    input  logic                             SCLK,
    input  logic                             SRESETn,
    input  logic                             retry_vld,
    input  logic [SRCID_W-1:0]               retry_srcid,
    input  logic [TXNID_W-1:0]               retry_txnid,
    input  logic [PCRDTYPE_W-1:0]            retry_pcrdtype,
    input  logic                             grant_vld,
    input  logic [SRCID_W-1:0]               grant_tgtid,
    input  logic [PCRDTYPE_W-1:0]            grant_pcrdtype,
    input  logic                             req_vld,
    input  logic [SRCID_W-1:0]               req_srcid,
    input  logic                             req_allowretry,
    input  logic [PCRDTYPE_W-1:0]            req_pcrdtype,
    output logic                             err_overflow,
    output logic                             err_unexp_grant,
    output logic                             err_no_credit,
    output logic                             err_bad_pcrdtype,
    output logic                             err_timeout,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] wait_cnt,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] grant_cnt,
    output logic                             full
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int TMR_W = (MAXWAIT > 1) ? $clog2(MAXWAIT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((MAXWAIT > 0) ? MAXWAIT - 1 : 0);
    localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_GRANT = 2'd1,
        GRANTED    = 2'd2
    } entryState_t;

    entryState_t             entState    [NUM_ENTRIES];
    logic [SRCID_W-1:0]      entSrcid    [NUM_ENTRIES];
    logic [TXNID_W-1:0]      entTxnid    [NUM_ENTRIES];
    logic [PCRDTYPE_W-1:0]   entPcrdtype [NUM_ENTRIES];
    logic [TMR_W-1:0]        entTimer    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0]  isFree, isWait, isGranted;
    logic [NUM_ENTRIES-1:0]  grantMatch, reqMatch, expire;
    logic [NUM_ENTRIES-1:0]  allocSel, grantSel, reqSel;
    logic [CNT_W-1:0]        waitSum, grantSum;
    logic                    unusedTxnid;

    // All matching looks only at the registered table, so same-cycle events never chain.
    always_comb begin
        isFree     = '0;
        isWait     = '0;
        isGranted  = '0;
        grantMatch = '0;
        reqMatch   = '0;
        expire     = '0;
        waitSum    = '0;
        grantSum   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            isFree[i]     = (entState[i] == FREE);
            isWait[i]     = (entState[i] == WAIT_GRANT);
            isGranted[i]  = (entState[i] == GRANTED);
            grantMatch[i] = isWait[i] && (entSrcid[i] == grant_tgtid)
                            && (entPcrdtype[i] == grant_pcrdtype);
            reqMatch[i]   = isGranted[i] && (entSrcid[i] == req_srcid)
                            && (entPcrdtype[i] == req_pcrdtype);
            expire[i]     = (MAXWAIT > 0) && isWait[i] && (entTimer[i] == TMR_LAST);
            waitSum       = waitSum + CNT_W'(isWait[i]);
            grantSum      = grantSum + CNT_W'(isGranted[i]);
        end
    end

    // v & -v isolates the lowest set bit, giving lowest-index priority.
    assign allocSel = retry_vld ? (isFree & (~isFree + ONE)) : '0;
    assign grantSel = grant_vld ? (grantMatch & (~grantMatch + ONE)) : '0;
    assign reqSel   = (req_vld && !req_allowretry) ? (reqMatch & (~reqMatch + ONE)) : '0;

    always_ff @(posedge SCLK or negedge SRESETn) begin
        if (!SRESETn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entState[i]    <= FREE;
                entSrcid[i]    <= '0;
                entTxnid[i]    <= '0;
                entPcrdtype[i] <= '0;
                entTimer[i]    <= '0;
            end
            err_overflow     <= 1'b0;
            err_unexp_grant  <= 1'b0;
            err_no_credit    <= 1'b0;
            err_bad_pcrdtype <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (allocSel[i]) begin
                    entState[i]    <= WAIT_GRANT;
                    entSrcid[i]    <= retry_srcid;
                    entTxnid[i]    <= retry_txnid;
                    entPcrdtype[i] <= retry_pcrdtype;
                    entTimer[i]    <= '0;
                end else begin
                    // A grant arriving in the expiry cycle still counts as on time.
                    if (grantSel[i]) begin
                        entState[i] <= GRANTED;
                    end else if (reqSel[i] || expire[i]) begin
                        entState[i] <= FREE;
                    end
                    if (isWait[i]) begin
                        entTimer[i] <= entTimer[i] + TMR_W'(1);
                    end
                end
            end
            err_overflow     <= retry_vld && !(|isFree);
            err_unexp_grant  <= grant_vld && !(|grantMatch);
            err_no_credit    <= req_vld && !req_allowretry && !(|reqMatch);
            err_bad_pcrdtype <= req_vld && req_allowretry && (|req_pcrdtype);
            err_timeout      <= |(expire & ~grantSel);
        end
    end

    // TxnID is recorded for debug visibility only; credits are not bound to it.
    always_comb begin
        unusedTxnid = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            unusedTxnid = unusedTxnid ^ (^entTxnid[i]);
        end
    end

    assign wait_cnt  = waitSum;
    assign grant_cnt = grantSum;
    assign full      = ~(|isFree);

endmodule
